// File: rtl/vga_scan_pkg.sv
// rtl/vga_scan_pkg.sv - shared scan timing constants, derived totals and coordinate type
//
// Shared by the scan generator, the colour detector and the overlay logic.
// Contents: default VGA 640x480 timing, default ROI window, h_total/v_total
// helpers, the 10-bit coordinate type and a half-open range test.
package vga_scan_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_ROI_X0 = 270;
  localparam int DEF_ROI_X1 = 370;
  localparam int DEF_ROI_Y0 = 160;
  localparam int DEF_ROI_Y1 = 320;

  // Largest count any axis may reach; coordinates are 10 bits wide.
  localparam int MAX_TOTAL = 1024;

  typedef logic [9:0] coord_t;

  function automatic int axis_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
    return axis_total(visible, fp, sync, bp);
  endfunction

  function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
    return axis_total(visible, fp, sync, bp);
  endfunction

  // Half-open test lo <= c < hi, done in int so bounds of 1024 do not alias to 0.
  function automatic logic in_band(input coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - one raster axis: wrapping counter with registered sync/visible decode
//
// Ports:
//   Clk, RST     clock, synchronous active-high reset
//   step         advance the counter by one position
//   count        current position, 0..TOTAL-1
//   count_next   position after this cycle (feeds decoders registered elsewhere)
//   wrap         high in the cycle the counter steps from TOTAL-1 back to 0
//   sync_n       low while count is inside the sync pulse
//   visible      high while count is inside the active region
module scan_axis_counter
  import vga_scan_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP
) (
  input  logic   Clk,
  input  logic   RST,
  input  logic   step,
  output coord_t count,
  output coord_t count_next,
  output logic   wrap,
  output logic   sync_n,
  output logic   visible
);

  localparam int     TOTAL   = axis_total(VISIBLE, FP, SYNC, BP);
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam int     SYNC_LO = VISIBLE + FP;
  localparam int     SYNC_HI = VISIBLE + FP + SYNC;

  assign wrap = step && (count == LAST);

  always_comb begin
    count_next = count;
    if (step) begin
      count_next = (count == LAST) ? '0 : count + coord_t'(1);
    end
  end

  // Flags are decoded from count_next so they land in the same edge as the
  // count itself; when step is low count_next == count and everything holds.
  always_ff @(posedge Clk) begin
    if (RST) begin
      count   <= '0;
      sync_n  <= !in_band('0, SYNC_LO, SYNC_HI);
      visible <= in_band('0, 0, VISIBLE);
    end else begin
      count   <= count_next;
      sync_n  <= !in_band(count_next, SYNC_LO, SYNC_HI);
      visible <= in_band(count_next, 0, VISIBLE);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan generator with sync, blank, strobes and optional ROI flag
//
// Optional feature macro: VGA_SCAN_ROI_EN (ROI window decoder; tied off when undefined).
// Ports:
//   Clk, RST            clock, synchronous active-high reset
//   pix_en              pixel-clock enable; scan advances only when high
//   Draw_X, Draw_Y      current column / row
//   hs_n, vs_n          active-low horizontal / vertical sync
//   blank_n             high while the position is visible
//   line_start          one-cycle pulse when Draw_X wraps to 0
//   frame_start         one-cycle pulse when the scan wraps to (0,0)
//   frame_count         completed frames, modulo 256
//   in_roi, roi_done    ROI membership and end-of-ROI pulse
module vga_scan_gen
  import vga_scan_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int ROI_X0    = DEF_ROI_X0,
  parameter int ROI_X1    = DEF_ROI_X1,
  parameter int ROI_Y0    = DEF_ROI_Y0,
  parameter int ROI_Y1    = DEF_ROI_Y1
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       pix_en,
  output coord_t     Draw_X,
  output coord_t     Draw_Y,
  output logic       hs_n,
  output logic       vs_n,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       in_roi,
  output logic       roi_done
);

  if (h_total(H_VISIBLE, H_FP, H_SYNC, H_BP) > MAX_TOTAL ||
      v_total(V_VISIBLE, V_FP, V_SYNC, V_BP) > MAX_TOTAL) begin : g_bad_total
    $error("vga_scan_gen: scan totals exceed 1024");
  end
  if (!(ROI_X0 < ROI_X1 && ROI_X1 <= H_VISIBLE &&
        ROI_Y0 < ROI_Y1 && ROI_Y1 <= V_VISIBLE)) begin : g_bad_roi
    $error("vga_scan_gen: ROI window outside the visible area or empty");
  end

  coord_t x_next, y_next;
  logic   h_wrap, v_wrap, v_step;
  logic   h_vis, v_vis;

  assign v_step = h_wrap && pix_en;

  scan_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .Clk        (Clk),
    .RST        (RST),
    .step       (pix_en),
    .count      (Draw_X),
    .count_next (x_next),
    .wrap       (h_wrap),
    .sync_n     (hs_n),
    .visible    (h_vis)
  );

  scan_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .Clk        (Clk),
    .RST        (RST),
    .step       (v_step),
    .count      (Draw_Y),
    .count_next (y_next),
    .wrap       (v_wrap),
    .sync_n     (vs_n),
    .visible    (v_vis)
  );

  // Both inputs are registered flags, so blank_n has no skew against the coordinates.
  assign blank_n = h_vis && v_vis;

  // h_wrap already includes pix_en, so strobes drop on enable-low cycles.
  always_ff @(posedge Clk) begin
    if (RST) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef VGA_SCAN_ROI_EN
  logic roi_q, roi_done_q;

  always_ff @(posedge Clk) begin
    if (RST) begin
      roi_q      <= in_band('0, ROI_X0, ROI_X1) && in_band('0, ROI_Y0, ROI_Y1);
      roi_done_q <= 1'b0;
    end else begin
      roi_q      <= in_band(x_next, ROI_X0, ROI_X1) && in_band(y_next, ROI_Y0, ROI_Y1);
      // Leaving the final ROI pixel marks the whole window as scanned.
      roi_done_q <= pix_en && (Draw_X == coord_t'(ROI_X1 - 1)) && (Draw_Y == coord_t'(ROI_Y1 - 1));
    end
  end

  assign in_roi   = roi_q;
  assign roi_done = roi_done_q;
`else
  logic unused_roi_next;
  assign unused_roi_next = ^{x_next, y_next};
  assign in_roi   = 1'b0;
  assign roi_done = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen against a frame-index reference model
module tb_vga_scan_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 10, VF = 1, VS = 2, VB = 2;
  localparam int RX0 = 4, RX1 = 10, RY0 = 3, RY1 = 7;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_SCAN_ROI_EN
  localparam bit ROI_ON = 1'b1;
`else
  localparam bit ROI_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] Draw_X, Draw_Y;
  logic       hs_n, vs_n, blank_n, line_start, frame_start, in_roi, roi_done;
  logic [7:0] frame_count;

  always #5 Clk = ~Clk;

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1)
  ) dut (
    .Clk(Clk), .RST(RST), .pix_en(pix_en),
    .Draw_X(Draw_X), .Draw_Y(Draw_Y),
    .hs_n(hs_n), .vs_n(vs_n), .blank_n(blank_n),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .in_roi(in_roi), .roi_done(roi_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: the scan is just a linear pixel index within the frame.
  int   m_p = 0;
  int   m_fc = 0;
  logic m_ls = 1'b0, m_fs = 1'b0, m_rd = 1'b0;

  wire [34:0] obs = {Draw_X, Draw_Y, hs_n, vs_n, blank_n, line_start, frame_start,
                     frame_count, in_roi, roi_done};

  task automatic tick(input logic en, input logic rst);
    int old;
    @(negedge Clk);
    pix_en = en;
    RST = rst;
    @(posedge Clk);
    #1;
    cyc++;
    if (rst) begin
      m_p = 0; m_fc = 0; m_ls = 1'b0; m_fs = 1'b0; m_rd = 1'b0;
    end else if (en) begin
      old  = m_p;
      m_p  = (m_p + 1) % FRAME;
      m_ls = (m_p % HT) == 0;
      m_fs = (m_p == 0);
      if (m_fs) m_fc = (m_fc + 1) % 256;
      m_rd = ROI_ON && (old == (RY1 - 1) * HT + (RX1 - 1));
    end else begin
      m_ls = 1'b0; m_fs = 1'b0; m_rd = 1'b0;
    end
  endtask

  function automatic logic [34:0] exp_vec();
    int   x = m_p % HT;
    int   y = m_p / HT;
    logic hs  = !(x >= HV + HF && x < HV + HF + HS);
    logic vs  = !(y >= VV + VF && y < VV + VF + VS);
    logic bl  = (x < HV) && (y < VV);
    logic roi = ROI_ON && (x >= RX0) && (x < RX1) && (y >= RY0) && (y < RY1);
    return {10'(x), 10'(y), hs, vs, bl, m_ls, m_fs, 8'(m_fc), roi, m_rd};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    checks++;
    if ({Draw_X, Draw_Y, hs_n, vs_n, blank_n, line_start, frame_start, roi_done, frame_count} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b rd=%b fc=%0d",
               Draw_X, Draw_Y, hs_n, vs_n, blank_n, line_start, frame_start, roi_done, frame_count);
    end
  endtask

  task automatic test_line();
    int   fall_x = -1, rise_x = -1, ls_seen = 0;
    logic prev_hs = hs_n;
    tick(1'b1, 1'b1);
    for (int i = 0; i < HT + 3; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL line_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (prev_hs && !hs_n && fall_x < 0) fall_x = int'(Draw_X);
      if (!prev_hs && hs_n && rise_x < 0) rise_x = int'(Draw_X);
      if (line_start) ls_seen++;
      prev_hs = hs_n;
    end
    checks++;
    if (fall_x != HV + HF) begin
      errors++;
      $display("FAIL hs_fall got x=%0d exp x=%0d", fall_x, HV + HF);
    end
    checks++;
    if (rise_x != HV + HF + HS) begin
      errors++;
      $display("FAIL hs_rise got x=%0d exp x=%0d", rise_x, HV + HF + HS);
    end
    checks++;
    if (ls_seen != 1) begin
      errors++;
      $display("FAIL line_start_count got=%0d exp=1", ls_seen);
    end
  endtask

  task automatic test_frames();
    int fs_cyc[$];
    int blank_cnt = 0, vs_low = 0, roi_cnt = 0, rd_cnt = 0;
    int px = 0, py = 0;
    tick(1'b1, 1'b1);
    fs_cyc.push_back(cyc);
    for (int i = 0; i < 3 * FRAME; i++) begin
      px = int'(Draw_X);
      py = int'(Draw_Y);
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL frame_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (blank_n) blank_cnt++;
      if (!vs_n) vs_low++;
      if (in_roi) roi_cnt++;
      if (roi_done) begin
        rd_cnt++;
        checks++;
        if (px != RX1 - 1 || py != RY1 - 1) begin
          errors++;
          $display("FAIL roi_done_pos got=(%0d,%0d) exp=(%0d,%0d)", px, py, RX1 - 1, RY1 - 1);
        end
      end
      if (frame_start) begin
        fs_cyc.push_back(cyc);
        checks++;
        if (line_start !== 1'b1) begin
          errors++;
          $display("FAIL line_with_frame got ls=%b exp=1", line_start);
        end
      end
      if (m_p == HV || m_p == VV * HT) begin
        checks++;
        if (blank_n !== 1'b0) begin
          errors++;
          $display("FAIL blank_corner at (%0d,%0d) got=%b exp=0", Draw_X, Draw_Y, blank_n);
        end
      end
    end
    checks++;
    if (fs_cyc.size() != 4) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=3", fs_cyc.size() - 1);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (fs_cyc[k] - fs_cyc[k-1] != FRAME) begin
          errors++;
          $display("FAIL frame_period got=%0d exp=%0d", fs_cyc[k] - fs_cyc[k-1], FRAME);
        end
      end
    end
    checks++;
    if (frame_count !== 8'd3) begin
      errors++;
      $display("FAIL frame_count got=%0d exp=3", frame_count);
    end
    checks++;
    if (blank_cnt != 3 * HV * VV) begin
      errors++;
      $display("FAIL blank_total got=%0d exp=%0d", blank_cnt, 3 * HV * VV);
    end
    checks++;
    if (vs_low != 3 * VS * HT) begin
      errors++;
      $display("FAIL vs_low_total got=%0d exp=%0d", vs_low, 3 * VS * HT);
    end
    checks++;
    if (roi_cnt != (ROI_ON ? 3 * (RX1 - RX0) * (RY1 - RY0) : 0)) begin
      errors++;
      $display("FAIL roi_total got=%0d exp=%0d", roi_cnt, ROI_ON ? 3 * (RX1 - RX0) * (RY1 - RY0) : 0);
    end
    checks++;
    if (rd_cnt != (ROI_ON ? 3 : 0)) begin
      errors++;
      $display("FAIL roi_done_total got=%0d exp=%0d", rd_cnt, ROI_ON ? 3 : 0);
    end
  endtask

  task automatic test_half_rate();
    int fs_cyc[$];
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4 * FRAME + 4; i++) begin
      tick(1'(i % 2 == 0), 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL half_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (frame_start) fs_cyc.push_back(cyc);
    end
    checks++;
    if (fs_cyc.size() < 2) begin
      errors++;
      $display("FAIL half_frames got=%0d starts exp>=2", fs_cyc.size());
    end else if (fs_cyc[1] - fs_cyc[0] != 2 * FRAME) begin
      errors++;
      $display("FAIL half_period got=%0d exp=%0d", fs_cyc[1] - fs_cyc[0], 2 * FRAME);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8 * HT + 17; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < FRAME; i++) tick(1'b1, 1'b0);
    checks++;
    if (Draw_X !== 10'd17 || Draw_Y !== 10'd8 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_pos got=(%0d,%0d) fc=%0d exp=(17,8) fc=1", Draw_X, Draw_Y, frame_count);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_vec got=%h exp=%h", obs, exp_vec());
    end
    checks++;
    if (frame_start !== 1'b0 || frame_count !== 8'd0 || Draw_X !== 10'd0 || Draw_Y !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset_state got fs=%b fc=%0d pos=(%0d,%0d) exp fs=0 fc=0 pos=(0,0)",
               frame_start, frame_count, Draw_X, Draw_Y);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_half_rate();
    test_random_enable();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Pixel-scan generator that produces the raster coordinates and sync/blank timing which the colour-detection and overlay logic consume. It advances a horizontal/vertical counter pair on each pixel-clock enable, decodes VGA sync and blanking, and emits frame and line strobes. It sits between the system clock domain and the camera-to-VGA pixel path, so every downstream pixel consumer sees a single consistent Draw_X/Draw_Y timebase. An optional region-of-interest decoder flags the detection window and signals when it has been fully scanned, so a downstream accumulator can latch its per-frame result.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- ROI_X0 / ROI_X1, 270 / 370, ROI column bounds, half-open [X0, X1)
- ROI_Y0 / ROI_Y1, 160 / 320, ROI row bounds, half-open [Y0, Y1)

Ports:
- Clk  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel-clock enable; the scan advances only when this is high
- Draw_X  out  10  current column, 0..H_TOTAL-1
- Draw_Y  out  10  current row, 0..V_TOTAL-1
- hs_n  out  1  horizontal sync, active-low
- vs_n  out  1  vertical sync, active-low
- blank_n  out  1  high while the current position is visible
- line_start  out  1  one-Clk pulse when Draw_X wraps to 0
- frame_start  out  1  one-Clk pulse when (Draw_X, Draw_Y) wraps to (0, 0)
- frame_count  out  8  count of completed frames, wraps modulo 256
- in_roi  out  1  current position is inside the ROI (macro-dependent)
- roi_done  out  1  one-Clk pulse after the last ROI pixel (macro-dependent)

## Operation
- Totals are fixed by the parameters: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
- Horizontal counter: increments on pix_en; at H_TOTAL-1 it wraps to 0 and generates a vertical step.
- Vertical counter: increments on a vertical step; at V_TOTAL-1 it wraps to 0 and frame_count increments.
- Decoding is a pure function of the registered counters, registered alongside them:
  - hs_n = 0 for Draw_X in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [656, 752) at defaults.
  - vs_n = 0 for Draw_Y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. [490, 492) at defaults.
  - blank_n = (Draw_X < H_VISIBLE) && (Draw_Y < V_VISIBLE).
- Strobes are asserted only for the Clk cycle in which the wrap is registered; they are never asserted out of reset.
- pix_en low: every counter and registered output holds its value; strobes deassert.
- Parameter constraints: all totals ≤ 1024; ROI_X0 < ROI_X1 ≤ H_VISIBLE; ROI_Y0 < ROI_Y1 ≤ V_VISIBLE. A violation is an elaboration-time error.

## Timing
- Reset values:
  - Draw_X = 0, Draw_Y = 0, frame_count = 0.
  - hs_n = 1, vs_n = 1, blank_n = 1.
  - line_start, frame_start, roi_done = 0.
  - in_roi = 0 at default parameters (i.e. the decoded value for position (0, 0)).
- Latency: all outputs change in the same Clk edge that consumes the pix_en which advanced the counters; there is zero skew between the coordinates and their decoded flags.
- Frame period: H_TOTAL*V_TOTAL pix_en pulses (420000 at defaults), measured frame_start to frame_start.
- RST mid-frame: returns all outputs to their reset values on the next edge, regardless of pix_en. The scan restarts at (0, 0) without a frame_start pulse, and frame_count clears to 0.
- Simultaneous line and frame wrap: line_start and frame_start both pulse in the same cycle.

## Configuration
- VGA_SCAN_ROI_EN defined:
  - in_roi = (ROI_X0 ≤ Draw_X < ROI_X1) && (ROI_Y0 ≤ Draw_Y < ROI_Y1), registered alongside the coordinates.
  - roi_done pulses for one Clk in the cycle the position advances away from (ROI_X1-1, ROI_Y1-1), i.e. leaving (369, 319) at defaults. It pulses exactly once per frame.
- VGA_SCAN_ROI_EN undefined: in_roi and roi_done are tied to 0 and no ROI comparators are built.

## Structure
- Shared package vga_scan_pkg holds:
  - default timing constants;
  - the derived H_TOTAL and V_TOTAL functions;
  - the 10-bit coordinate typedef, shared with the detector and overlay logic.
- One sub-module, scan_axis_counter (parameters VISIBLE, FP, SYNC, BP), instantiated twice:
  - inputs: step enable;
  - outputs: count, wrap pulse, sync_n, visible.
  - The vertical instance is stepped by the horizontal wrap AND pix_en.

## Test plan
- RST held, then released with pix_en = 1 -> Draw_X steps 0,1,2…; hs_n first falls at Draw_X = 656 and rises at 752; line_start pulses when 799 wraps to 0.
- pix_en continuously high -> frame_start pulses every 420000 cycles; vs_n is low only for Draw_Y 490–491; frame_count reads 3 after three full frames.
- pix_en toggling 1-of-2 (25 MHz from 50 MHz) -> outputs hold on low cycles; frame period becomes 840000 Clk.
- RST asserted at (400, 300) -> next edge gives (0, 0) with reset output values, no frame_start, frame_count = 0.
- VGA_SCAN_ROI_EN defined -> in_roi is high for exactly 16000 pixels per frame; roi_done pulses once, on leaving (369, 319).
- blank_n check over a full frame -> 307200 high positions per frame; blank_n is low at (640, 0) and at (0, 480).
